mem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RISC-V pipeline.
- Sequences each access through an FSM, returns read data to the winning requester and drives per-requester stall signals that the pipeline uses to freeze IF and MEM.
- Data-side accesses have priority, because they belong to the older instruction.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/mem_lat_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the memory-port arbiter: FSM state encodings, grant
// encodings and the default memory latency.
package cpu_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int DEF_MEM_LAT = 1;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag; times the fixed memory read latency.
module mem_lat_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (IF) and load/store (MEM).
// Optional IF starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              take_d;
    logic              force_i;
    logic              cnt_zero;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;

    // Counts IF losses in IDLE; once saturated at STARVE_MAX, IF takes the next collision.
    always_comb begin
        starve_d = starve_q;
        force_i  = (starve_q >= SW'(STARVE_MAX));
        if (state_q == ST_IDLE && if_req) begin
            starve_d = (d_req && !force_i) ? starve_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX != 0);
    assign force_i           = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        take_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_req || if_req) begin
                    take_d  = d_req && !(if_req && force_i);
                    gnt_d   = take_d ? GNT_D : GNT_I;
                    addr_d  = take_d ? d_addr : if_addr;
                    we_d    = take_d && d_we;
                    be_d    = take_d ? d_be : '1;
                    wdata_d = take_d ? d_wdata : wdata_q;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (cnt_zero) begin
                    if (gnt_q == GNT_I) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= GNT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == ST_ISSUE),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .dec      (state_q == ST_WAIT),
        .zero     (cnt_zero)
    );

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_be    = mem_en ? be_q : '0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_ready  = (state_q == ST_RESP) && (gnt_q == GNT_I);
    assign d_ready   = (state_q == ST_RESP) && (gnt_q == GNT_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req && !if_ready;
    assign stall_mem = d_req && !d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level arbitration model,
// behavioural latency memory, and a monitor that checks every access and response.
module tb_mem_port_arbiter;

    localparam int LAT  = 3;
    localparam int SMAX = 2;

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ready, d_req, d_we, d_ready;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, mem_be;
    logic        stall_if, stall_mem, mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'h0050_0093;
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // ---------------- behavioural memory with fixed read latency ----------------
    logic [31:0]    dev_mem [256];
    logic [LAT-1:0] rd_vld    = '0;
    logic [31:0]    rd_dat [LAT];
    logic           init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= init_word(i);
            init_done <= 1'b1;
        end
        rd_vld[0] <= mem_en && !mem_we;
        rd_dat[0] <= dev_mem[mem_addr[9:2]];
        for (int k = 1; k < LAT; k++) begin
            rd_vld[k] <= rd_vld[k-1];
            rd_dat[k] <= rd_dat[k-1];
        end
        if (init_done && mem_en && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) dev_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    assign mem_rdata = rd_vld[LAT-1] ? rd_dat[LAT-1] : {16'hBAD0, cyc[15:0]};

    // ---------------- reference model and scoreboard queues ----------------
    logic [31:0] ref_mem [256];
    logic [31:0] last_d = '0;
    int          starve_cnt = 0;
    txn_t        i_txn[$], d_txn[$];
    txn_t        iss_q[$];
    rsp_t        rsp_q[$];

    // Walks the pending IF/D transaction lists in arbitration order: D wins
    // collisions unless the starvation guard is active and saturated.
    task automatic predict(input int r);
        int   t  = r;
        int   ii = 0;
        int   di = 0;
        bit   hi, hd, take_d;
        txn_t e;
        rsp_t rs;
        logic [31:0] rdata;
        while (ii < i_txn.size() || di < d_txn.size()) begin
            hi = ii < i_txn.size();
            hd = di < d_txn.size();
            if (hi && hd) begin
`ifdef ARB_STARVE_GUARD_EN
                take_d = starve_cnt < SMAX;
`else
                take_d = 1'b1;
`endif
            end else begin
                take_d = hd;
            end
            if (hi) starve_cnt = take_d ? starve_cnt + 1 : 0;
            if (take_d) begin e = d_txn[di]; di++; end
            else        begin e = i_txn[ii]; ii++; end
            iss_q.push_back(e);
            if (e.is_d && e.we) begin
                rdata = last_d;
                for (int b = 0; b < 4; b++)
                    if (e.be[b]) ref_mem[e.addr[9:2]][8*b +: 8] = e.wdata[8*b +: 8];
            end else begin
                rdata = ref_mem[e.addr[9:2]];
            end
            if (e.is_d) last_d = rdata;
            rs.is_d  = e.is_d;
            rs.rdata = rdata;
            rs.cyc   = t + 2 + LAT;
            rsp_q.push_back(rs);
            t = t + 3 + LAT;
        end
    endtask

    // ---------------- monitor ----------------
    txn_t mon_e;
    rsp_t mon_r;

    always @(negedge clk) begin
        if (!reset) begin
            check("stall_if", 32'(stall_if), 32'(if_req && !if_ready));
            check("stall_mem", 32'(stall_mem), 32'(d_req && !d_ready));
            if (mem_en) begin
                if (iss_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mem_en: unexpected access addr=0x%08h expected none", mem_addr);
                end else begin
                    mon_e = iss_q.pop_front();
                    check("mem_addr", mem_addr, mon_e.addr);
                    check("mem_we", 32'(mem_we), 32'(mon_e.we));
                    if (mon_e.we) begin
                        check("mem_be", 32'(mem_be), 32'(mon_e.be));
                        check("mem_wdata", mem_wdata, mon_e.wdata);
                    end
                end
            end else begin
                check("mem_we_idle", 32'(mem_we), 32'd0);
                check("mem_be_idle", 32'(mem_be), 32'd0);
            end
            if (if_ready || d_ready) begin
                if (rsp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ready: unexpected pulse if=%0b d=%0b expected none", if_ready, d_ready);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("ready_who", 32'({if_ready, d_ready}), mon_r.is_d ? 32'd1 : 32'd2);
                    check("ready_cycle", 32'(cyc), 32'(mon_r.cyc));
                    check("rdata", mon_r.is_d ? d_rdata : if_rdata, mon_r.rdata);
                end
            end
        end
    end

    // ---------------- driver ----------------
    function automatic txn_t mk(input bit is_d, input bit we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.is_d = is_d; t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic txn_t rand_txn(input bit is_d);
        bit          we   = is_d && ($urandom_range(0, 1) == 1);
        logic [31:0] addr = {22'd0, 8'($urandom_range(0, 47)), 2'b00};
        return mk(is_d, we, we ? 4'($urandom_range(1, 15)) : 4'hF, addr, is_d ? $urandom : 32'd0);
    endfunction

    task automatic drive_d(input txn_t t);
        d_req = 1'b1; d_we = t.we; d_be = t.be; d_addr = t.addr; d_wdata = t.wdata;
    endtask

    // Presents both lists from the same cycle; each requester offers its next
    // transaction in the cycle after its ready, otherwise drops req.
    task automatic drive_scn();
        bit hi, hd, ri, rd;
        int n = 0;
        @(posedge clk); #1;
        predict(cyc);
        hi = i_txn.size() > 0;
        hd = d_txn.size() > 0;
        if (hi) begin if_req = 1'b1; if_addr = i_txn.pop_front().addr; end
        if (hd) drive_d(d_txn.pop_front());
        while ((hi || hd) && n < 200) begin
            @(negedge clk);
            ri = if_ready;
            rd = d_ready;
            @(posedge clk); #1;
            n++;
            if (ri && hi) begin
                if (i_txn.size() > 0) if_addr = i_txn.pop_front().addr;
                else begin if_req = 1'b0; hi = 1'b0; end
            end
            if (rd && hd) begin
                if (d_txn.size() > 0) drive_d(d_txn.pop_front());
                else begin d_req = 1'b0; hd = 1'b0; end
            end
        end
        if (hi || hd) begin
            total++;
            bad++;
            $display("FAIL timeout: requests still pending after %0d cycles, expected completion", n);
            if_req = 1'b0; d_req = 1'b0;
            i_txn.delete(); d_txn.delete();
        end
        repeat (LAT + 4) @(posedge clk);
        #1;
        check("iss_left", 32'(iss_q.size()), 32'd0);
        check("rsp_left", 32'(rsp_q.size()), 32'd0);
        iss_q.delete();
        rsp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({if_ready, d_ready, stall_if, stall_mem, mem_en, mem_we}), 32'd0);
        check({tag, "_be"}, 32'(mem_be), 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int diffs;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // lone fetch
        i_txn.push_back(mk(1'b0, 1'b0, 4'hF, 32'h100, 32'd0));
        drive_scn();

        // lone store, then inspect the memory word it targeted
        d_txn.push_back(mk(1'b1, 1'b1, 4'hF, 32'h200, 32'hDEAD_BEEF));
        drive_scn();
        check("store_landed", dev_mem[128], 32'hDEAD_BEEF);

        // collision: load wins, fetch follows on the next IDLE
        i_txn.push_back(mk(1'b0, 1'b0, 4'hF, 32'h104, 32'd0));
        d_txn.push_back(mk(1'b1, 1'b0, 4'hF, 32'h300, 32'd0));
        drive_scn();

        // reset while waiting on the memory: aborted, no ready
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h108;
        iss_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h108, 32'd0));
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; if_req = 1'b0;
        starve_cnt = 0;
        last_d = '0;
        @(negedge clk);
        check_all_zero("abort");
        check("abort_iss", 32'(iss_q.size()), 32'd0);
        repeat (LAT + 3) @(posedge clk);
        i_txn.push_back(mk(1'b0, 1'b0, 4'hF, 32'h10C, 32'd0));
        drive_scn();

        // sustained collision: exercises strict priority or the starvation guard
        for (int k = 0; k < 4; k++) d_txn.push_back(mk(1'b1, 1'b0, 4'hF, 32'h180 + 32'(4 * k), 32'd0));
        i_txn.push_back(mk(1'b0, 1'b0, 4'hF, 32'h140, 32'd0));
        i_txn.push_back(mk(1'b0, 1'b0, 4'hF, 32'h144, 32'd0));
        drive_scn();

        // randomized traffic
        for (int s = 0; s < 30; s++) begin
            int ni = $urandom_range(0, 3);
            int nd = $urandom_range(ni == 0 ? 1 : 0, 3);
            for (int k = 0; k < ni; k++) i_txn.push_back(rand_txn(1'b0));
            for (int k = 0; k < nd; k++) d_txn.push_back(rand_txn(1'b1));
            drive_scn();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        diffs = 0;
        for (int i = 0; i < 256; i++) if (dev_mem[i] !== ref_mem[i]) diffs++;
        check("mem_image_diffs", 32'(diffs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
